vin_wr_burst: RTL and testbench

//  Downstream of the input pixel/address generator: accepts per-pixel writes (valid, {y,x<<2} address, 16b data),

---
 rtl/vin_wr_pkg.sv | 16 +
 rtl/vin_wr_fifo.sv | 42 ++++
 rtl/vin_wr_burst.sv | 199 +++++++++++++++++++
 tb/tb_vin_wr_burst.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vin_wr_pkg.sv
// Shared widths, output FSM states and burst command layout for the video-in
// write burster.
package vin_wr_pkg;
  localparam int ADDR_W = 32;
  localparam int PIX_W  = 16;
  localparam int LEN_W  = 8;
  localparam int X_LSB  = 2;
  localparam int CMD_W  = ADDR_W + LEN_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA} wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_cmd_t;
endpackage

// File: rtl/vin_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO and a pop from an empty one are ignored.
module vin_wr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic                     vin_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge vin_clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge vin_clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/vin_wr_burst.sv
// Groups contiguous same-line pixel writes into frame-buffer bursts.
// Optional statistics (ovf_err, burst_cnt) are built when VIN_WR_STATS_EN is defined.
module vin_wr_burst
  import vin_wr_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int DATA_DEPTH = 64,
  parameter int CMD_DEPTH  = 4
) (
  input  logic              vin_clk,
  input  logic              rst,
  input  logic              frame_sync_n,
  input  logic [15:0]       vin_xres,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] vin_addr,
  input  logic [PIX_W-1:0]  vin_wr_dat,
  output logic              vout_ready,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [LEN_W-1:0]  mem_cmd_len,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              mem_wlast
`ifdef VIN_WR_STATS_EN
  ,
  output logic              ovf_err,
  output logic [15:0]       burst_cnt
`endif
);
  localparam int DCW = $clog2(DATA_DEPTH) + 1;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;

  logic [DCW-1:0]    data_cnt;
  logic [CCW-1:0]    cmd_cnt;
  logic              pix_empty, cmd_empty, pix_pop, cmd_pop, cmd_push;
  logic [PIX_W-1:0]  pix_dout;
  burst_cmd_t        cmd_din, cmd_dout;

  logic              pend, pend_d;
  logic [LEN_W-1:0]  beats, beats_d, nb;
  logic [ADDR_W-1:0] start, start_d;
  logic              acc, x_eol, open, contig;

  wr_state_e         state, state_d;
  logic [LEN_W-1:0]  beat, len_q;

  assign vout_ready = !rst && !pend &&
                      (data_cnt <= DCW'(DATA_DEPTH-1)) && (cmd_cnt <= CCW'(CMD_DEPTH-2));
  assign acc    = wr_valid && vout_ready && frame_sync_n;
  assign x_eol  = ({2'b00, vin_addr[15:X_LSB]} == vin_xres - 16'd1);
  assign open   = (beats != '0);
  assign contig = open && (vin_addr == start + (ADDR_W'(beats) << X_LSB));

  // A discontinuity that also ends the new burst needs two command pushes;
  // the second is parked in pend and issued next cycle while ready is held low.
  always_comb begin
    cmd_push = 1'b0;
    cmd_din  = '0;
    beats_d  = beats;
    start_d  = start;
    pend_d   = pend;
    nb       = '0;
    if (pend) begin
      cmd_push = 1'b1;
      cmd_din  = '{addr: start, len: beats - LEN_W'(1)};
      beats_d  = '0;
      pend_d   = 1'b0;
    end else if (!frame_sync_n) begin
      if (open) begin
        cmd_push = 1'b1;
        cmd_din  = '{addr: start, len: beats - LEN_W'(1)};
      end
      beats_d = '0;
    end else if (acc) begin
      if (contig) begin
        nb = beats + LEN_W'(1);
      end else begin
        nb      = LEN_W'(1);
        start_d = vin_addr;
        if (open) begin
          cmd_push = 1'b1;
          cmd_din  = '{addr: start, len: beats - LEN_W'(1)};
        end
      end
      beats_d = nb;
      if (nb == LEN_W'(BURST_LEN) || x_eol) begin
        if (cmd_push) begin
          pend_d = 1'b1;
        end else begin
          cmd_push = 1'b1;
          cmd_din  = '{addr: start_d, len: nb - LEN_W'(1)};
          beats_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge vin_clk) begin
    if (rst) begin
      beats <= '0;
      start <= '0;
      pend  <= 1'b0;
    end else begin
      beats <= beats_d;
      start <= start_d;
      pend  <= pend_d;
    end
  end

  vin_wr_fifo #(.W(PIX_W), .DEPTH(DATA_DEPTH)) u_pix_fifo (
    .vin_clk (vin_clk),
    .rst     (rst),
    .push    (acc),
    .din     (vin_wr_dat),
    .pop     (pix_pop),
    .dout    (pix_dout),
    .empty   (pix_empty),
    .count   (data_cnt)
  );

  vin_wr_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .vin_clk (vin_clk),
    .rst     (rst),
    .push    (cmd_push),
    .din     (cmd_din),
    .pop     (cmd_pop),
    .dout    (cmd_dout),
    .empty   (cmd_empty),
    .count   (cmd_cnt)
  );

  // The command stays at the FIFO head until accepted, so the address is stable.
  always_comb begin
    state_d       = state;
    cmd_pop       = 1'b0;
    pix_pop       = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_len   = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    mem_wlast     = 1'b0;
    case (state)
      IDLE: if (!cmd_empty) state_d = CMD;
      CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = cmd_dout.addr;
        mem_cmd_len   = cmd_dout.len;
        if (mem_cmd_ready) begin
          cmd_pop = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        mem_wvalid = !pix_empty;
        mem_wdata  = pix_empty ? '0 : pix_dout;
        mem_wlast  = !pix_empty && (beat == len_q);
        if (mem_wvalid && mem_wready) begin
          pix_pop = 1'b1;
          if (mem_wlast) state_d = cmd_empty ? IDLE : CMD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vin_clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      len_q <= '0;
    end else begin
      state <= state_d;
      if (cmd_pop) begin
        len_q <= cmd_dout.len;
        beat  <= '0;
      end else if (pix_pop) begin
        beat  <= beat + LEN_W'(1);
      end
    end
  end

`ifdef VIN_WR_STATS_EN
  always_ff @(posedge vin_clk) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (wr_valid && !vout_ready) ovf_err <= 1'b1;
      if (!frame_sync_n)
        burst_cnt <= '0;
      else if (mem_cmd_valid && mem_cmd_ready && burst_cnt != 16'hFFFF)
        burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vin_wr_burst.sv
// Directed scoreboard bench for vin_wr_burst; stats checks build when VIN_WR_STATS_EN is defined.
module tb_vin_wr_burst;
  logic        vin_clk = 1'b0;
  logic        rst, frame_sync_n, wr_valid, mem_cmd_ready, wr_rdy, tog_en, tog_q;
  logic [15:0] vin_xres, vin_wr_dat, mem_wdata;
  logic [31:0] vin_addr, mem_cmd_addr;
  logic [7:0]  mem_cmd_len;
  logic        vout_ready, mem_cmd_valid, mem_wvalid, mem_wready, mem_wlast;
`ifdef VIN_WR_STATS_EN
  logic        ovf_err;
  logic [15:0] burst_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [39:0] exp_cmd[$];
  logic [16:0] exp_dat[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 vin_clk = ~vin_clk;
  always @(posedge vin_clk) tog_q <= ~tog_q;
  assign mem_wready = tog_en ? tog_q : wr_rdy;

  vin_wr_burst dut (
    .vin_clk       (vin_clk),
    .rst           (rst),
    .frame_sync_n  (frame_sync_n),
    .vin_xres      (vin_xres),
    .wr_valid      (wr_valid),
    .vin_addr      (vin_addr),
    .vin_wr_dat    (vin_wr_dat),
    .vout_ready    (vout_ready),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_len   (mem_cmd_len),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .mem_wdata     (mem_wdata),
    .mem_wlast     (mem_wlast)
`ifdef VIN_WR_STATS_EN
    ,
    .ovf_err       (ovf_err),
    .burst_cnt     (burst_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ad(input int y, input int x);
    logic [31:0] yv, xv;
    yv = y;
    xv = x;
    return {yv[15:0], xv[13:0], 2'b00};
  endfunction

  task automatic ecmd(input logic [31:0] a, input logic [7:0] l);
    exp_cmd.push_back({a, l});
  endtask

  // One pixel: hold it until the bench sees ready, then expect its data beat.
  task automatic px(input logic [31:0] a, input logic [15:0] d, input logic last);
    int t = 0;
    wr_valid = 1'b1; vin_addr = a; vin_wr_dat = d;
    @(negedge vin_clk);
    while (!vout_ready && t < 1000) begin @(negedge vin_clk); t++; end
    chk("px_ready_wait", 64'(t < 1000), 1);
    exp_dat.push_back({last, d});
    @(posedge vin_clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic fsync();
    frame_sync_n = 1'b0;
    @(posedge vin_clk); #1;
    frame_sync_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_cmd.size() != 0 || exp_dat.size() != 0) && t < 3000) begin
      @(negedge vin_clk); t++;
    end
    chk(tag, 64'(t < 3000), 1);
    repeat (2) @(posedge vin_clk);
    #1;
  endtask

  // Scoreboard: every handshake on the write port is matched against the queues.
  always @(negedge vin_clk) begin
    if (!rst) begin
      if (hold_prev) chk("cmd_addr_stable", mem_cmd_addr, prev_addr);
      hold_prev = mem_cmd_valid && !mem_cmd_ready;
      prev_addr = mem_cmd_addr;
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", mem_cmd_addr, 64'hDEAD);
        else begin
          logic [39:0] e;
          e = exp_cmd.pop_front();
          chk("cmd_addr", mem_cmd_addr, e[39:8]);
          chk("cmd_len", mem_cmd_len, e[7:0]);
        end
      end
      if (mem_wvalid && mem_wready) begin
        if (exp_dat.size() == 0) chk("beat_unexpected", mem_wdata, 64'hDEAD);
        else begin
          logic [16:0] e;
          e = exp_dat.pop_front();
          chk("wdata", mem_wdata, e[15:0]);
          chk("wlast", mem_wlast, e[16]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_sync_n = 1'b1; wr_valid = 1'b0; vin_addr = '0; vin_wr_dat = '0;
    vin_xres = 16'd32; mem_cmd_ready = 1'b1; wr_rdy = 1'b1; tog_en = 1'b0; tog_q = 1'b0;
    repeat (3) @(posedge vin_clk);
    #1;
    chk("rst_ready", vout_ready, 0);
    rst = 1'b0;
    @(negedge vin_clk);
    chk("post_rst_ready", vout_ready, 1);
    chk("post_rst_cmd_valid", mem_cmd_valid, 0);
    chk("post_rst_wvalid", mem_wvalid, 0);
    chk("post_rst_wlast", mem_wlast, 0);
    chk("post_rst_cmd_addr", mem_cmd_addr, 0);
`ifdef VIN_WR_STATS_EN
    chk("post_rst_ovf", ovf_err, 0);
    chk("post_rst_burst_cnt", burst_cnt, 0);
`endif
    @(posedge vin_clk); #1;

    // Full 32-pixel line splits into two 16-beat bursts.
    ecmd(ad(0, 0), 8'd15);
    for (int x = 0; x < 16; x++) px(ad(0, x), 16'h1000 + 16'(x), x == 15);
    ecmd(ad(0, 16), 8'd15);
    for (int x = 16; x < 32; x++) px(ad(0, x), 16'h1000 + 16'(x), x == 31);
    drain("drain_line32");

    // 20-pixel lines: 16 + 4 per line.
    vin_xres = 16'd20;
    for (int y = 0; y < 2; y++) begin
      ecmd(ad(y, 0), 8'd15);
      for (int x = 0; x < 16; x++) px(ad(y, x), 16'h2000 + 16'(y*32 + x), x == 15);
      ecmd(ad(y, 16), 8'd3);
      for (int x = 16; x < 20; x++) px(ad(y, x), 16'h2000 + 16'(y*32 + x), x == 19);
    end
    drain("drain_xres20");

    // Frame sync closes a short burst.
    vin_xres = 16'd32;
    ecmd(ad(2, 0), 8'd4);
    for (int x = 0; x < 5; x++) px(ad(2, x), 16'h3000 + 16'(x), x == 4);
    fsync();
    drain("drain_fsync");

    // Stalled command port: non-contiguous pixels fill the command FIFO.
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ecmd(ad(4, 2*i), 8'd0);
      px(ad(4, 2*i), 16'h4000 + 16'(i), 1'b1);
    end
    @(negedge vin_clk);
    chk("stall_ready_low", vout_ready, 0);
    @(posedge vin_clk); #1;
    wr_valid = 1'b1; vin_addr = ad(4, 20); vin_wr_dat = 16'hBAD0;
    repeat (3) @(posedge vin_clk);
    #1;
    wr_valid = 1'b0;
    repeat (200) @(posedge vin_clk);
    @(negedge vin_clk);
    chk("stall_ready_still_low", vout_ready, 0);
    chk("stall_cmd_valid", mem_cmd_valid, 1);
    chk("stall_cmd_addr", mem_cmd_addr, ad(4, 0));
    chk("stall_no_beats", mem_wvalid, 0);
`ifdef VIN_WR_STATS_EN
    chk("ovf_set", ovf_err, 1);
`endif
    @(posedge vin_clk); #1;
    mem_cmd_ready = 1'b1;
    repeat (12) @(posedge vin_clk);
    #1;
    fsync();
    drain("drain_stall");

    // Toggling write-ready with contiguous data.
    tog_en = 1'b1;
    ecmd(ad(3, 0), 8'd15);
    for (int x = 0; x < 16; x++) px(ad(3, x), 16'h5000 + 16'(x*3), x == 15);
    drain("drain_toggle");
    tog_en = 1'b0;

    // Four end-of-line bursts in a fresh frame.
    fsync();
    vin_xres = 16'd4;
    for (int y = 6; y < 10; y++) begin
      ecmd(ad(y, 0), 8'd3);
      for (int x = 0; x < 4; x++) px(ad(y, x), 16'h6000 + 16'(y*4 + x), x == 3);
    end
    drain("drain_stats");
    @(negedge vin_clk);
    chk("final_cmd_idle", mem_cmd_valid, 0);
    chk("final_w_idle", mem_wvalid, 0);
`ifdef VIN_WR_STATS_EN
    chk("burst_cnt_4", burst_cnt, 4);
    @(posedge vin_clk); #1;
    fsync();
    @(negedge vin_clk);
    chk("burst_cnt_clr", burst_cnt, 0);
    chk("ovf_sticky", ovf_err, 1);
`endif
    chk("sb_cmd_empty", exp_cmd.size(), 0);
    chk("sb_dat_empty", exp_dat.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
